// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master.
// Contents:
//   MAX_DIV_W   widest clk_div the master supports; the top's DIV_W must not exceed it
//   spi_state_t transfer FSM states
//   spi_cfg_t   per-transfer configuration captured when a start is accepted
package spi_pkg;

  localparam int MAX_DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } spi_state_t;

  typedef struct packed {
    logic                 cpol;
    logic                 cpha;
    logic                 lsb_first;
    logic                 hold_cs;
    logic [MAX_DIV_W-1:0] div;
  } spi_cfg_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timing for the SPI master: half-period counter, sclk level and edge strobes.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   count_en    run the half-period counter (cleared while low)
//   div         half-period select; one half-period lasts div+1 clk cycles
//   toggle_en   toggle sclk at the end of each half-period
//   load        force sclk to load_val at the next edge (has priority over toggling)
//   load_val    level loaded into sclk
//   cpol        idle level of the running transfer; used to classify edges
//   hp_end      last cycle of the current half-period
//   lead        strobe: sclk is about to leave its idle level
//   trail       strobe: sclk is about to return to its idle level
//   sclk        registered SPI clock
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 count_en,
  input  logic [MAX_DIV_W-1:0] div,
  input  logic                 toggle_en,
  input  logic                 load,
  input  logic                 load_val,
  input  logic                 cpol,
  output logic                 hp_end,
  output logic                 lead,
  output logic                 trail,
  output logic                 sclk
);

  logic [DIV_W-1:0] cnt;

  // Upper bits of div are always zero, so comparing the zero-extended counter is exact.
  assign hp_end = count_en && (MAX_DIV_W'(cnt) == div);
  assign lead   = toggle_en && hp_end && (sclk == cpol);
  assign trail  = toggle_en && hp_end && (sclk != cpol);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!count_en || hp_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk <= 1'b0;
    end else if (load) begin
      sclk <= load_val;
    end else if (toggle_en && hp_end) begin
      sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: configurable word width, runtime SCLK divider, CPOL/CPHA,
// MSB/LSB-first, several chip selects, CS hold for bursts and abort.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        request a transfer; taken only while tx_ready=1
//   abort        end any transfer (or held CS) and release all chip selects
//   tx_data, cs_sel, hold_cs, cpol, cpha, lsb_first, clk_div
//                per-transfer settings, captured on an accepted start
//   tx_ready     idle and able to take a start (also high in the done cycle)
//   done         one-cycle pulse, rx_data valid
//   rx_data      last received word, held until the next done
//   sclk, mosi   registered SPI clock and serial output
//   miso         serial input
//   cs_n         registered active-low chip selects
module spi_master_gen
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_CS = 4,
  parameter  int DIV_W  = 8,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              hold_cs,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              tx_ready,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int CNT_W = $clog2(2 * DATA_W) + 1;

  spi_state_t        state, state_nx;
  spi_cfg_t          cfg;
  logic              started;
  logic              accept;
  logic              hp_end, lead, trail;
  logic              shift_edge, sample_edge, last_edge;
  logic              idle_pol;
  logic [CNT_W-1:0]  edge_cnt;
  logic [DATA_W-1:0] tx_ord, tx_sreg, rx_sreg, rx_q;
  logic [NUM_CS-1:0] cs_dec;

  assign accept    = start && tx_ready && !abort;
  assign last_edge = (edge_cnt == CNT_W'(2 * DATA_W - 1));

  // Before the first transfer the idle level follows the cpol input directly.
  assign idle_pol  = started ? cfg.cpol : cpol;

  // CPHA=0 samples on leading edges and shifts on trailing ones (the final trailing
  // edge would push a bit that is never sampled); CPHA=1 swaps the roles.
  assign shift_edge  = cfg.cpha ? lead : (trail && !last_edge);
  assign sample_edge = cfg.cpha ? trail : lead;

  spi_clk_gen #(
    .DIV_W (DIV_W)
  ) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .count_en  ((state != IDLE) && !abort),
    .div       (cfg.div),
    .toggle_en (state == SHIFT),
    .load      ((state == IDLE) || abort || accept),
    .load_val  (accept ? cpol : idle_pol),
    .cpol      (cfg.cpol),
    .hp_end    (hp_end),
    .lead      (lead),
    .trail     (trail),
    .sclk      (sclk)
  );

  // Word in transmit order: the next bit to send always sits at the MSB.
  always_comb begin
    tx_ord = tx_data;
    if (lsb_first) begin
      for (int i = 0; i < DATA_W; i++) begin
        tx_ord[i] = tx_data[DATA_W-1-i];
      end
    end
  end

  // An out-of-range cs_sel matches no output, so the transfer runs with every CS released.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs_sel) == i) begin
        cs_dec[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The done cycle is the last HOLD cycle; it also reports ready so a burst can chain.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    tx_ready = (state == IDLE);
    if (state == HOLD && hp_end) begin
      done     = 1'b1;
      tx_ready = 1'b1;
    end
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = SETUP;
        SETUP:   if (hp_end) state_nx = SHIFT;
        SHIFT:   if (hp_end && last_edge) state_nx = HOLD;
        HOLD:    if (hp_end) state_nx = start ? SETUP : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg     <= '0;
      started <= 1'b0;
    end else if (accept) begin
      cfg.cpol      <= cpol;
      cfg.cpha      <= cpha;
      cfg.lsb_first <= lsb_first;
      cfg.hold_cs   <= hold_cs;
      cfg.div       <= MAX_DIV_W'(clk_div);
      started       <= 1'b1;
    end
  end

  // A new start replaces any held CS in one step; otherwise CS is released at the end
  // of a non-held word.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      cs_n <= '1;
    end else if (accept) begin
      cs_n <= cs_dec;
    end else if (done && !cfg.hold_cs) begin
      cs_n <= '1;
    end
  end

  // For CPHA=0 the first bit is already on mosi, so the register keeps only the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      mosi     <= 1'b0;
      tx_sreg  <= '0;
      rx_sreg  <= '0;
      rx_q     <= '0;
      edge_cnt <= '0;
    end else begin
      if (accept) begin
        mosi     <= tx_ord[DATA_W-1];
        tx_sreg  <= cpha ? tx_ord : (tx_ord << 1);
        edge_cnt <= '0;
      end else if (state == SHIFT && hp_end) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
      if (shift_edge) begin
        mosi    <= tx_sreg[DATA_W-1];
        tx_sreg <= tx_sreg << 1;
      end
      if (sample_edge) begin
        rx_sreg <= cfg.lsb_first ? {miso, rx_sreg[DATA_W-1:1]}
                                 : {rx_sreg[DATA_W-2:0], miso};
      end
      if (done) begin
        rx_q <= rx_sreg;
      end
    end
  end

  // The receive register is stable through HOLD, so it can be shown in the done cycle itself.
  assign rx_data = done ? rx_sreg : rx_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench for spi_master_gen (DATA_W=8, NUM_CS=4, DIV_W=8).
// A slave model reacts to observed sclk edges; expectations come from the SPI rules.
module tb_spi_master_gen;

  localparam int DW  = 8;
  localparam int NCS = 4;

  logic           clk = 1'b0;
  logic           reset, start, abort, hold_cs, cpol, cpha, lsb_first, miso;
  logic [DW-1:0]  tx_data, rx_data;
  logic [1:0]     cs_sel;
  logic [7:0]     clk_div;
  logic           tx_ready, done, sclk, mosi;
  logic [NCS-1:0] cs_n;
  logic           loop_en, slv_miso;
  logic [DW-1:0]  last_rx;

  int vectors     = 0;
  int miscompares = 0;

  assign miso = loop_en ? mosi : slv_miso;

  always #5 clk = ~clk;

  spi_master_gen #(
    .DATA_W (DW),
    .NUM_CS (NCS),
    .DIV_W  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .tx_data   (tx_data),
    .cs_sel    (cs_sel),
    .hold_cs   (hold_cs),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .clk_div   (clk_div),
    .tx_ready  (tx_ready),
    .done      (done),
    .rx_data   (rx_data),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // k-th bit on the wire (k=0 first) of a word sent in the given order.
  function automatic logic bit_at(input logic [DW-1:0] w, input int k, input logic lsb);
    if (k >= DW) return 1'b0;
    return lsb ? w[k] : w[DW-1-k];
  endfunction

  function automatic logic [NCS-1:0] exp_cs(input int sel);
    logic [NCS-1:0] r;
    r = '1;
    if (sel >= 0 && sel < NCS) r[sel] = 1'b0;
    return r;
  endfunction

  task automatic checkQuiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done !== 1'b0) hits++;
    end
    checkOutput(tag, 32'(hits), 32'd0);
  endtask

  // One transfer. chain=1 returns in the done cycle so the next call starts back-to-back.
  // abort_at>0 aborts once that many sclk edges have been seen.
  task automatic applyStimulus(input logic [DW-1:0] txw, input int sel, input logic hold,
                               input logic cp, input logic ph, input logic lsb, input int dv,
                               input logic [DW-1:0] sw, input logic chain, input int abort_at);
    int n, toggles, lead_k, trail_k, exp_done, budget, pos;
    logic prev_sclk, cs_ok, seen;
    logic [DW-1:0] mosi_w, exp_rx;
    logic [NCS-1:0] ecs;

    budget = 0;
    while (tx_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("ready_wait", 32'(tx_ready), 32'd1);

    tx_data = txw; cs_sel = 2'(sel); hold_cs = hold; cpol = cp; cpha = ph;
    lsb_first = lsb; clk_div = 8'(dv); start = 1'b1;
    slv_miso = ph ? 1'b0 : bit_at(sw, 0, lsb);

    exp_done = (2 * DW + 2) * (dv + 1);
    exp_rx   = loop_en ? txw : sw;
    ecs      = exp_cs(sel);
    cs_ok = 1'b1; seen = 1'b0; prev_sclk = cp;
    toggles = 0; lead_k = 0; trail_k = 0; mosi_w = '0; n = 0;

    while (!seen && n < exp_done + 20) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) checkOutput("sclk_setup_level", 32'(sclk), 32'(cp));
      if (cs_n !== ecs) cs_ok = 1'b0;
      if (sclk !== prev_sclk) begin
        toggles++;
        if (sclk !== cp) begin
          if (lead_k < DW) begin
            pos = lsb ? lead_k : DW - 1 - lead_k;
            mosi_w[pos] = mosi;
          end
          if (ph) slv_miso = bit_at(sw, lead_k, lsb);
          lead_k++;
        end else begin
          trail_k++;
          if (!ph) slv_miso = bit_at(sw, trail_k, lsb);
        end
        prev_sclk = sclk;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        checkOutput("done_cycle", 32'(n), 32'(exp_done));
        checkOutput("rx_data", 32'(rx_data), 32'(exp_rx));
        checkOutput("ready_in_done", 32'(tx_ready), 32'd1);
        checkOutput("sclk_end_level", 32'(sclk), 32'(cp));
        last_rx = exp_rx;
      end else begin
        // Junk while busy: a start and new settings must all be ignored.
        start = ($urandom_range(0, 3) == 0);
        tx_data = DW'($urandom); cs_sel = 2'($urandom); hold_cs = 1'($urandom);
        cpol = 1'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom);
        clk_div = 8'($urandom);
      end
      if (abort_at > 0 && toggles == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abort_cs", 32'(cs_n), 32'hF);
        checkOutput("abort_ready", 32'(tx_ready), 32'd1);
        checkOutput("abort_sclk", 32'(sclk), 32'(cp));
        checkOutput("abort_rx_kept", 32'(rx_data), 32'(last_rx));
        checkQuiet("abort_no_done", 3 * exp_done);
        return;
      end
    end

    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    checkOutput("sclk_toggles", 32'(toggles), 32'(2 * DW));
    checkOutput("mosi_word", 32'(mosi_w), 32'(txw));
    checkOutput("cs_during", 32'(cs_ok), 32'd1);

    if (!chain) begin
      start = 1'b0;
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("cs_after", 32'(cs_n), 32'(hold ? ecs : exp_cs(NCS)));
      checkOutput("rx_held", 32'(rx_data), 32'(last_rx));
      checkOutput("sclk_idle", 32'(sclk), 32'(cp));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] t, s;
    int sel, dv;
    logic h, cp, ph, lsb, ch;

    reset = 1'b1; start = 1'b0; abort = 1'b0; tx_data = '0; cs_sel = '0; hold_cs = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = '0; loop_en = 1'b0;
    slv_miso = 1'b0; last_rx = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sclk", 32'(sclk), 32'd0);
    checkOutput("reset_mosi", 32'(mosi), 32'd0);
    checkOutput("reset_cs", 32'(cs_n), 32'hF);
    checkOutput("reset_rx", 32'(rx_data), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 32'(tx_ready), 32'd1);

    $display("[TB] mode 0 loopback");
    loop_en = 1'b1;
    applyStimulus(8'hA5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h00, 1'b0, 0);
    loop_en = 1'b0;

    $display("[TB] modes 1..3 against slave model");
    for (int m = 1; m < 4; m++) begin
      applyStimulus(8'h3C, 1, 1'b0, m[1], m[0], 1'b0, 1, 8'hC3, 1'b0, 0);
    end

    $display("[TB] lsb first");
    applyStimulus(8'h01, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h01, 1'b0, 0);

    $display("[TB] held burst on cs 2");
    applyStimulus(8'h11, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h22, 1'b1, 0);
    applyStimulus(8'h33, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h44, 1'b1, 0);
    applyStimulus(8'h55, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h66, 1'b0, 0);

    $display("[TB] abort in idle with held cs");
    applyStimulus(8'h5A, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h96, 1'b0, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("idle_abort_cs", 32'(cs_n), 32'hF);

    $display("[TB] abort mid-word");
    applyStimulus(8'hE7, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 8'h18, 1'b0, 8);

    $display("[TB] start and abort together");
    tx_data = 8'h81; cs_sel = 2'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("start_abort_ready", 32'(tx_ready), 32'd1);
    checkOutput("start_abort_cs", 32'(cs_n), 32'hF);
    checkQuiet("start_abort_no_done", 60);

    $display("[TB] clk_div 0");
    applyStimulus(8'h69, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h4B, 1'b0, 0);

    $display("[TB] randomized transfers");
    for (int i = 0; i < 14; i++) begin
      t = DW'($urandom); s = DW'($urandom); sel = $urandom_range(0, NCS - 1);
      h = 1'($urandom); cp = 1'($urandom); ph = 1'($urandom); lsb = 1'($urandom);
      dv = $urandom_range(0, 3); ch = 1'($urandom);
      loop_en = 1'($urandom);
      applyStimulus(t, sel, h, cp, ph, lsb, dv, s, ch, 0);
    end
    start = 1'b0;
    loop_en = 1'b0;
    repeat (80) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
